vector_writeback_queue: RTL

- Write-back stage that directly feeds the vector register file's write port: write_addr, write_vector and the per-lane we mask.
- Merges results from two producers, the vector ALU and the vector load unit.
- Buffers results in a small in-order FIFO and retires at most one 128-bit, 4-lane write per cycle through registered outputs.
- Exports a per-register pending bitmap for decode hazard stalls.

---
 rtl/vector_writeback_queue_pkg.sv | 33 +++
 rtl/vector_writeback_queue_fifo.sv | 88 ++++++++
 rtl/vector_writeback_queue.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vector_writeback_queue_pkg.sv
// Shared types for the vector write-back path.
//   Lane/vector geometry, register address width, the queued write-back
//   entry struct, and a lane-merge helper.
package vector_pkg;
    localparam int VECTOR_REG_SIZE  = 32;   // bits per lane
    localparam int VECTOR_REG_WIDTH = 4;    // lanes per vector
    localparam int NUM_VREGS        = 32;   // architectural vector registers
    localparam int VREG_AW          = $clog2(NUM_VREGS);
    localparam int VEC_BITS         = VECTOR_REG_SIZE * VECTOR_REG_WIDTH;

    typedef logic [VREG_AW-1:0]          vreg_addr_t;
    typedef logic [VECTOR_REG_WIDTH-1:0] vlane_mask_t;
    typedef logic [VEC_BITS-1:0]         vector_t;

    typedef struct packed {
        vreg_addr_t  addr;
        vector_t     data;
        vlane_mask_t mask;
    } wb_entry_t;

    // Overlay the lanes enabled in m onto e; the union of masks is kept.
    function automatic wb_entry_t wb_merge(input wb_entry_t e, input vector_t d,
                                           input vlane_mask_t m);
        wb_entry_t r;
        r = e;
        for (int l = 0; l < VECTOR_REG_WIDTH; l++) begin
            if (m[l])
                r.data[l*VECTOR_REG_SIZE +: VECTOR_REG_SIZE] = d[l*VECTOR_REG_SIZE +: VECTOR_REG_SIZE];
        end
        r.mask = e.mask | m;
        return r;
    endfunction
endpackage

// File: rtl/vector_writeback_queue_fifo.sv
// vwb_fifo: in-order write-back entry storage with two ordered push ports
// (port 0 is older), one pop port and an in-place rewrite of the youngest
// entry (used for coalescing).
// Ports:
//   clk, rst                 clock, async active-high reset
//   i_push0/i_push0_entry    enqueue at tail
//   i_push1/i_push1_entry    enqueue behind push0 (or at tail if no push0)
//   i_pop                    retire head
//   i_merge/i_merge_entry    overwrite entry at tail-1
//   o_head                   head entry
//   o_youngest               entry at tail-1 (VWB_COALESCE_EN builds only)
//   o_slot_addr/o_slot_vld   per-slot address and occupancy
//   o_count                  occupancy
// Macro: VWB_COALESCE_EN adds the o_youngest port.
module vwb_fifo
    import vector_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push0,
    input  wb_entry_t                    i_push0_entry,
    input  logic                         i_push1,
    input  wb_entry_t                    i_push1_entry,
    input  logic                         i_pop,
    input  logic                         i_merge,
    input  wb_entry_t                    i_merge_entry,
    output wb_entry_t                    o_head,
`ifdef VWB_COALESCE_EN
    output wb_entry_t                    o_youngest,
`endif
    output vreg_addr_t [DEPTH-1:0]       o_slot_addr,
    output logic       [DEPTH-1:0]       o_slot_vld,
    output logic       [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic [PW-1:0]     w_tail_m1;
    logic [PW-1:0]     w_push1_idx;

    assign w_tail_m1   = r_tail - PW'(1);
    assign w_push1_idx = r_tail + PW'(i_push0);

    // Payload storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (i_merge) r_mem[w_tail_m1]   <= i_merge_entry;
        if (i_push0) r_mem[r_tail]      <= i_push0_entry;
        if (i_push1) r_mem[w_push1_idx] <= i_push1_entry;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + PW'(i_push0) + PW'(i_push1);
            r_head  <= r_head + PW'(i_pop);
            r_count <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
        end
    end

    always_comb begin
        logic [PW-1:0] off;
        off         = '0;
        o_slot_vld  = '0;
        o_slot_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off            = PW'(i) - r_head;
            o_slot_vld[i]  = ({1'b0, off} < r_count);
            o_slot_addr[i] = r_mem[i].addr;
        end
    end

    assign o_head     = r_mem[r_head];
`ifdef VWB_COALESCE_EN
    assign o_youngest = r_mem[w_tail_m1];
`endif
    assign o_count    = r_count;
endmodule

// File: rtl/vector_writeback_queue.sv
// vector_writeback_queue: merges ALU and load results into an in-order
// queue and retires at most one 4-lane vector write per cycle into the
// vector register file through registered outputs.
// Ports:
//   clk, rst                                     clock, async active-high reset
//   alu_valid/ready/addr/vector/mask             ALU result channel (older on ties)
//   ld_valid/ready/addr/vector/mask              load result channel
//   write_addr, write_vector, we                 register-file write port (registered)
//   pending                                      per-register in-flight bitmap
//   count                                        queue occupancy
// Macro: VWB_COALESCE_EN merges a result into the youngest queued entry
//   with the same destination instead of allocating a new slot.
module vector_writeback_queue
    import vector_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  vreg_addr_t                   alu_addr,
    input  vector_t                      alu_vector,
    input  vlane_mask_t                  alu_mask,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  vreg_addr_t                   ld_addr,
    input  vector_t                      ld_vector,
    input  vlane_mask_t                  ld_mask,
    output vreg_addr_t                   write_addr,
    output vector_t                      write_vector,
    output vlane_mask_t                  we,
    output logic [NUM_VREGS-1:0]         pending,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);

    logic [CW-1:0]          w_count;
    wb_entry_t              w_head;
    vreg_addr_t [DEPTH-1:0] w_slot_addr;
    logic [DEPTH-1:0]       w_slot_vld;

    logic       w_pop, w_push0, w_push1, w_merge;
    logic       w_alu_nz, w_ld_nz, w_ld_base;
    wb_entry_t  w_alu_e, w_ld_e, w_push0_e, w_merge_e;

    vreg_addr_t  r_write_addr;
    vector_t     r_write_vector;
    vlane_mask_t r_we;

    assign w_alu_nz = |alu_mask;
    assign w_ld_nz  = |ld_mask;
    assign w_alu_e  = '{addr: alu_addr, data: alu_vector, mask: alu_mask};
    assign w_ld_e   = '{addr: ld_addr,  data: ld_vector,  mask: ld_mask};
    assign w_pop    = (w_count != '0);

    // Ready looks only at registered occupancy; a slot freed by this cycle's
    // pop is not reused until next cycle. The load yields the last slot to the ALU.
    assign w_ld_base = (w_count < DEPTH_M1) | (~alu_valid & (w_count < DEPTH_C));

`ifdef VWB_COALESCE_EN
    wb_entry_t w_yng;
    logic      w_yng_ok, w_alu_hit, w_alu_alloc;
    logic      w_ld_hit_new, w_ld_hit_old, w_ld_hit;

    // With one entry left it is the head and leaves this cycle, so only a
    // queue of two or more has a mergeable youngest entry.
    assign w_yng_ok     = (w_count >= CW'(2));
    assign w_alu_hit    = alu_valid & w_alu_nz & w_yng_ok & (alu_addr == w_yng.addr);
    assign alu_ready    = (w_count < DEPTH_C) | w_alu_hit;
    assign w_alu_alloc  = alu_valid & alu_ready & w_alu_nz & ~w_alu_hit;
    // The load's "youngest" is the ALU entry if the ALU allocates this cycle.
    assign w_ld_hit_new = w_alu_alloc & (ld_addr == alu_addr);
    assign w_ld_hit_old = ~w_alu_alloc & w_yng_ok & (ld_addr == w_yng.addr);
    assign w_ld_hit     = ld_valid & w_ld_nz & (w_ld_hit_new | w_ld_hit_old);
    assign ld_ready     = w_ld_base | w_ld_hit;

    assign w_push0 = w_alu_alloc;
    assign w_push1 = ld_valid & ld_ready & w_ld_nz & ~w_ld_hit;
    assign w_merge = w_alu_hit | (w_ld_hit & w_ld_hit_old);

    // ALU is applied before load so the load's lanes win on overlap.
    always_comb begin
        w_push0_e = w_alu_e;
        w_merge_e = w_yng;
        if (w_ld_hit & w_ld_hit_new)
            w_push0_e = wb_merge(w_push0_e, ld_vector, ld_mask);
        if (w_alu_hit)
            w_merge_e = wb_merge(w_merge_e, alu_vector, alu_mask);
        if (w_ld_hit & w_ld_hit_old)
            w_merge_e = wb_merge(w_merge_e, ld_vector, ld_mask);
    end
`else
    assign alu_ready = (w_count < DEPTH_C);
    assign ld_ready  = w_ld_base;
    // Zero-mask results complete the handshake but never occupy a slot.
    assign w_push0   = alu_valid & alu_ready & w_alu_nz;
    assign w_push1   = ld_valid & ld_ready & w_ld_nz;
    assign w_merge   = 1'b0;

    always_comb begin
        w_push0_e = w_alu_e;
        w_merge_e = '0;
    end
`endif

    vwb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_push0       (w_push0),
        .i_push0_entry (w_push0_e),
        .i_push1       (w_push1),
        .i_push1_entry (w_ld_e),
        .i_pop         (w_pop),
        .i_merge       (w_merge),
        .i_merge_entry (w_merge_e),
        .o_head        (w_head),
`ifdef VWB_COALESCE_EN
        .o_youngest    (w_yng),
`endif
        .o_slot_addr   (w_slot_addr),
        .o_slot_vld    (w_slot_vld),
        .o_count       (w_count)
    );

    // Output stage: address/data hold when idle, only we drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write_addr   <= '0;
            r_write_vector <= '0;
            r_we           <= '0;
        end else if (w_pop) begin
            r_write_addr   <= w_head.addr;
            r_write_vector <= w_head.data;
            r_we           <= w_head.mask;
        end else begin
            r_we           <= '0;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_vld[i]) pending[w_slot_addr[i]] = 1'b1;
        end
        if (|r_we) pending[r_write_addr] = 1'b1;
    end

    assign write_addr   = r_write_addr;
    assign write_vector = r_write_vector;
    assign we           = r_we;
    assign count        = w_count;
endmodule
